// File: rtl/fcvt_f2i_pipe.sv
// Two-stage pipelined float-to-integer converter (FCVT.W.S / FCVT.WU.S).
// Stage 1 classifies the operand and aligns the significand to an integer
// magnitude plus guard/sticky bits. Stage 2 rounds by the requested mode,
// saturates, applies the sign and raises NV/NX. Both stages sit behind a
// valid/ready handshake and the result is fully registered.
module fcvt_f2i_pipe #(
   parameter int F_EXP     = 8,
   parameter int F_FLAC    = 23,
   parameter int I_WIDTH   = 32,
   parameter int TAG_WIDTH = 5
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [F_EXP+F_FLAC:0]   in1,
   input  logic                    is_signed,
   input  logic [2:0]              rm,
   input  logic [TAG_WIDTH-1:0]    in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [I_WIDTH-1:0]      out1,
   output logic [TAG_WIDTH-1:0]    out_tag,
   output logic                    invalid,
   output logic                    inexact
);

   localparam int BIAS = 2**(F_EXP-1) - 1;
   // aligned width: I_WIDTH integer bits over F_FLAC+1 fraction bits
   localparam int XW   = I_WIDTH + F_FLAC + 1;

   localparam logic [I_WIDTH-1:0] MAX_S = {1'b0, {(I_WIDTH-1){1'b1}}};
   localparam logic [I_WIDTH-1:0] MIN_S = {1'b1, {(I_WIDTH-1){1'b0}}};
   localparam logic [I_WIDTH-1:0] ALL1  = {I_WIDTH{1'b1}};

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RDN = 3'd2,
      RM_RUP = 3'd3,
      RM_RMM = 3'd4
   } rm_e;

   // ---------------- stage 1: decode / align ----------------
   logic                     sign_d;
   logic [F_EXP-1:0]         exp_f;
   logic [F_FLAC-1:0]        frac_f;
   logic                     exp_max, nan_d, inf_d, big_d;
   logic signed [31:0]       e_unb;
   logic [31:0]              sh;
   logic [XW-1:0]            x_al;
   logic [I_WIDTH-1:0]       mag_d;
   logic                     g_d, s_d;

   assign sign_d  = in1[F_EXP+F_FLAC];
   assign exp_f   = in1[F_FLAC +: F_EXP];
   assign frac_f  = in1[F_FLAC-1:0];
   assign exp_max = &exp_f;
   assign nan_d   = exp_max & (|frac_f);
   assign inf_d   = exp_max & ~(|frac_f);
   assign e_unb   = $signed(32'(exp_f)) - BIAS;
   assign big_d   = (e_unb >= I_WIDTH);
   // shift so that the binary point lands between x_al[F_FLAC+1] and x_al[F_FLAC]
   assign sh      = e_unb + 32'sd1;

   // Align {1,frac} to integer magnitude, guard and sticky.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the ifs below can leave it unassigned and infer a latch.
      x_al  = '0;
      mag_d = '0;
      g_d   = 1'b0;
      s_d   = 1'b0;
      if (exp_max || big_d) begin
         // NaN, inf or too large: magnitude is irrelevant, saturation decides
      end else if (e_unb < -1) begin
         // below 0.5 (includes zero and every subnormal): only sticky survives
         s_d = |in1[F_EXP+F_FLAC-1:0];
      end else begin
         x_al  = {{I_WIDTH{1'b0}}, 1'b1, frac_f} << sh;
         mag_d = x_al[XW-1 -: I_WIDTH];
         g_d   = x_al[F_FLAC];
         s_d   = |x_al[F_FLAC-1:0];
      end
   end

   logic                  s1_valid, s2_valid, s2_en;
   logic                  s1_sign, s1_nan, s1_inf, s1_big, s1_signed, s1_g, s1_s;
   logic [2:0]            s1_rm;
   logic [TAG_WIDTH-1:0]  s1_tag;
   logic [I_WIDTH-1:0]    s1_mag;

   assign s2_en     = ~s2_valid | out_ready;
   assign in_ready  = ~s1_valid | s2_en;
   assign out_valid = s2_valid;

   // Stage 1 occupancy: refilled (or emptied) whenever it can accept.
   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (RST)           s1_valid <= 1'b0;
      else if (in_ready) s1_valid <= in_valid;
   end

   // Stage 1 payload, captured on acceptance.
   always_ff @(posedge CLK) begin
      // NOTE: payload registers are qualified by s1_valid, so they need no
      // reset; only the valid bits and the visible outputs are cleared.
      if (in_valid && in_ready) begin
         s1_sign   <= sign_d;
         s1_nan    <= nan_d;
         s1_inf    <= inf_d;
         s1_big    <= big_d;
         s1_signed <= is_signed;
         s1_rm     <= rm;
         s1_tag    <= in_tag;
         s1_mag    <= mag_d;
         s1_g      <= g_d;
         s1_s      <= s_d;
      end
   end

   // ---------------- stage 2: round / saturate ----------------
   logic                inc, exact;
   logic [I_WIDTH:0]    r_mag;
   logic [I_WIDTH-1:0]  res, sat_val;
   logic                nv, nx;

   // Round, range-check and sign the aligned magnitude.
   always_comb begin
      inc = 1'b0;
      case (s1_rm)
         RM_RNE:  inc = s1_g & (s1_s | s1_mag[0]);
         RM_RDN:  inc = s1_sign & (s1_g | s1_s);
         RM_RUP:  inc = ~s1_sign & (s1_g | s1_s);
         RM_RMM:  inc = s1_g;
         default: inc = 1'b0;   // RTZ and reserved encodings
      endcase
      r_mag   = {1'b0, s1_mag} + {{I_WIDTH{1'b0}}, inc};
      exact   = ~(s1_g | s1_s);
      sat_val = s1_signed ? (s1_sign ? MIN_S : MAX_S) : (s1_sign ? '0 : ALL1);
      res     = '0;
      nv      = 1'b0;
      if (s1_nan) begin
         res = s1_signed ? MAX_S : ALL1;
         nv  = 1'b1;
      end else if (s1_inf || s1_big) begin
         res = sat_val;
         nv  = 1'b1;
      end else if (s1_signed) begin
         if ((!s1_sign && r_mag > {1'b0, MAX_S}) || (s1_sign && r_mag > {1'b0, MIN_S})) begin
            res = sat_val;
            nv  = 1'b1;
         end else begin
            res = s1_sign ? ('0 - r_mag[I_WIDTH-1:0]) : r_mag[I_WIDTH-1:0];
         end
      end else begin
         if (s1_sign) begin
            res = '0;
            nv  = |r_mag;
         end else if (r_mag[I_WIDTH]) begin
            res = ALL1;
            nv  = 1'b1;
         end else begin
            res = r_mag[I_WIDTH-1:0];
         end
      end
      nx = ~exact & ~nv;
   end

   // Output register: loads when empty or drained, holds while stalled.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s2_valid <= 1'b0;
         out1     <= '0;
         out_tag  <= '0;
         invalid  <= 1'b0;
         inexact  <= 1'b0;
      end else if (s2_en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out1    <= res;
            out_tag <= s1_tag;
            invalid <= nv;
            inexact <= nx;
         end
      end
   end

endmodule

// File: doc/fcvt_f2i_pipe.md
# fcvt_f2i_pipe

Two-stage pipelined float-to-integer converter for the FP execution path. It implements FCVT.W.S and FCVT.WU.S semantics with all five RISC-V static rounding modes, signed or unsigned selection per operation, NV/NX exception flags and a tag passthrough. It is the registered, rounding-aware successor to the combinational truncating FCVT.WU.S unit. It sits between FP issue and integer writeback, behind a valid/ready handshake.

## Interface
- F_EXP, 8, exponent width; bias = 2^(F_EXP-1)-1
- F_FLAC, 23, stored fraction width
- I_WIDTH, 32, result integer width (≥ 8)
- TAG_WIDTH, 5, opaque tag carried alongside each operation (e.g. rd index)
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  stage 1 can accept
- in1  in  1+F_EXP+F_FLAC  IEEE operand
- is_signed  in  1  1 = FCVT.W (signed), 0 = FCVT.WU
- rm  in  3  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5–7 are executed as RTZ
- in_tag  in  TAG_WIDTH  tag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out1  out  I_WIDTH  converted integer
- out_tag  out  TAG_WIDTH  tag of out1
- invalid  out  1  NV flag for out1
- inexact  out  1  NX flag for out1

## Operation
- Stage 1 (decode/align), registered on acceptance:
  - Classify the operand: zero, subnormal, normal, inf, NaN.
  - Unbiased exponent e = exp − bias.
  - If e ≥ I_WIDTH: set `big`; magnitude is don't-care.
  - Else shift {1, frac} (or {0, frac} for subnormal) so that the register holds mag[I_WIDTH-1:0] = integer part, plus guard bit G and sticky S (OR of all lower bits).
  - e < −1: mag = 0, G = 0, S = nonzero operand.
  - Carry sign, is_signed, rm and tag.
- Stage 2 (round/saturate), registered:
  - Increment by rm: RNE: G & (S | mag[0]). RTZ: never. RDN: sign & (G | S). RUP: ~sign & (G | S). RMM: G.
  - Rounded magnitude R is I_WIDTH+1 bits wide; carry-out is kept.
  - Exact when G = S = 0.
- Result selection, in priority order:
  - NaN: signed gives 2^(W-1)-1; unsigned gives all ones. NV = 1.
  - Inf or `big`: saturate by sign. Signed: + gives 2^(W-1)-1, − gives 2^(W-1). Unsigned: + gives all ones, − gives 0. NV = 1. Exception: signed, − sign, exp = bias+W−1, frac = 0 is exactly −2^(W-1); that case gives 2^(W-1), NV = 0, NX = 0.
  - Signed finite: if R > 2^(W-1)−1 (positive) or R > 2^(W-1) (negative), saturate as above with NV = 1. Otherwise out1 = sign ? −R : R.
  - Unsigned finite: if sign and R ≠ 0, out1 = 0 with NV = 1. If sign and R = 0, out1 = 0 with NX per exactness. If positive and R ≥ 2^W (carry-out), out1 = all ones with NV = 1. Otherwise out1 = R.
  - NX = ~exact, and is forced to 0 whenever NV = 1.
  - Zero of either sign: out1 = 0, no flags.

## Timing
- Latency is 2 cycles from in_valid & in_ready to out_valid, with no bubbles.
- Throughput is 1 operation per cycle while out_ready = 1.
- Handshake: each stage register holds a valid bit.
  - s2 loads when ~s2_valid | out_ready.
  - s1 advances into s2 under the same condition.
  - in_ready = ~s1_valid | (~s2_valid | out_ready). This is combinational from out_ready.
- A held result must keep out1, out_tag and the flags stable while out_valid & ~out_ready.
- Simultaneous accept at input and output in the same cycle is legal and loses nothing.
- Order is strictly FIFO.
- Reset, asynchronous, including mid-operation:
  - s1_valid = s2_valid = 0.
  - out1 = 0, out_tag = 0, invalid = 0, inexact = 0.
  - In-flight operations are discarded.
  - in_ready = 1 after reset.

## Test plan
All cases use the default parameters.
- Rounding modes:
  - 2.5 (0x40200000), signed: RNE→2, RTZ→2, RDN→2, RUP→3, RMM→3; NX = 1 for all.
  - −2.5 (0xC0200000): RDN→0xFFFFFFFD, RUP→0xFFFFFFFE.
- Unsigned negatives:
  - −1.5 (0xBFC00000), RTZ→0, NV = 1, NX = 0.
  - −0.4 (0xBECCCCCD), RNE→0, NV = 0, NX = 1.
- Bounds:
  - 2^31 (0x4F000000): signed→0x7FFFFFFF NV = 1; unsigned→0x80000000, no flags.
  - −2^31 (0xCF000000): signed→0x80000000, no flags.
  - 4294967040.0 (0x4F7FFFFF): unsigned RUP→0xFFFFFF00, exact.
- Specials:
  - qNaN 0x7FC00000: signed→0x7FFFFFFF, unsigned→0xFFFFFFFF, NV = 1.
  - −inf: signed→0x80000000 NV = 1.
  - −0.0→0, no flags.
- Backpressure:
  - Issue 4 back-to-back operations with out_ready = 0 for 5 cycles. in_ready must drop after 2 are accepted.
  - Release out_ready: all 4 results emerge in order with tags 1..4, held stable while stalled.
- Reset mid-flight: assert RST with both stages valid. Required: out_valid = 0, all outputs = 0 immediately, and the next operation completes with 2-cycle latency.
